// File: rtl/seg_status_scan_if.sv
// seg_status_scan_if: status inputs and display outputs between the fault/input sources and the 7-segment driver.
// Ports: mem_calib_done, mem_error, vga_buf_empty, clear_sticky, buf_inputs (to scanner);
//        seg_digits, sticky_flags (from scanner). master = source side, slave = scanner.
interface seg_status_scan_if #(
    parameter int NUM_INPUTS = 14,
    parameter int NUM_DIGITS = 3
);
    logic                    mem_calib_done;
    logic                    mem_error;
    logic                    vga_buf_empty;
    logic                    clear_sticky;
    logic [NUM_INPUTS-1:0]   buf_inputs;
    logic [4*NUM_DIGITS-1:0] seg_digits;
    logic [1:0]              sticky_flags;

    modport master (
        output mem_calib_done, mem_error, vga_buf_empty, clear_sticky, buf_inputs,
        input  seg_digits, sticky_flags
    );

    modport slave (
        input  mem_calib_done, mem_error, vga_buf_empty, clear_sticky, buf_inputs,
        output seg_digits, sticky_flags
    );
endinterface

// File: rtl/seg_status_scan.sv
// seg_status_scan: registered status word with sticky faults and a dwell-timed scan of active inputs.
// Ports: clk, rst (sync, active high); bus (slave) carries the status inputs, buf_inputs,
//        seg_digits (registered display word) and sticky_flags ({vga_sticky, mem_sticky}).
module seg_status_scan #(
    parameter int          NUM_INPUTS     = 14,
    parameter int          NUM_DIGITS     = 3,
    parameter int          HOLD_CYCLES    = 25000000,
    parameter logic [31:0] CODE_UNCALIB   = 32'hC00,
    parameter logic [31:0] CODE_MEM_ERR   = 32'hE01,
    parameter logic [31:0] CODE_VGA_EMPTY = 32'hE02,
    parameter logic [31:0] CODE_DEFAULT   = 32'hFFF
) (
    input logic             clk,
    input logic             rst,
    seg_status_scan_if.slave bus
);
    localparam int W  = 4 * NUM_DIGITS;
    localparam int IW = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [W-1:0]  C_UNCAL   = W'(CODE_UNCALIB);
    localparam logic [W-1:0]  C_MEM     = W'(CODE_MEM_ERR);
    localparam logic [W-1:0]  C_VGA     = W'(CODE_VGA_EMPTY);
    localparam logic [W-1:0]  C_DEF     = W'(CODE_DEFAULT);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

    typedef enum logic {IDLE, SHOW} state_t;

    state_t        r_state, w_state_n;
    logic [IW-1:0] r_idx, w_idx_n, w_low, w_above;
    logic [HW-1:0] r_cnt, w_cnt_n;
    logic [W-1:0]  r_seg, w_seg_n, w_bcd;
    logic          r_mem, r_vga, w_mem_n, w_vga_n, w_fault, w_expire, w_above_vld, w_any;

    assign w_any    = |bus.buf_inputs;
    assign w_expire = (r_cnt == HOLD_LAST);

    // A fault seen this cycle sets the flag even when clear_sticky is also asserted.
    assign w_mem_n = bus.mem_calib_done & (bus.mem_error | (r_mem & ~bus.clear_sticky));
    assign w_vga_n = bus.mem_calib_done & (bus.vga_buf_empty | (r_vga & ~bus.clear_sticky));
    assign w_fault = ~bus.mem_calib_done | w_mem_n | w_vga_n;

    // Scanning downwards leaves the lowest matching bit as the final assignment.
    always_comb begin
        w_low       = '0;
        w_above     = '0;
        w_above_vld = 1'b0;
        for (int i = NUM_INPUTS - 1; i >= 0; i--) begin
            if (bus.buf_inputs[i]) begin
                w_low = IW'(i);
                if (i > int'(r_idx)) begin
                    w_above     = IW'(i);
                    w_above_vld = 1'b1;
                end
            end
        end
    end

    always_comb begin
        w_state_n = r_state;
        w_idx_n   = r_idx;
        w_cnt_n   = r_cnt;
        if (w_fault) begin
            w_state_n = IDLE;
            w_cnt_n   = '0;
        end else if (r_state == IDLE) begin
            if (w_any) begin
                w_state_n = SHOW;
                w_idx_n   = w_low;
                w_cnt_n   = '0;
            end
        end else if (w_expire) begin
            w_cnt_n = '0;
            if (!w_any) w_state_n = IDLE;
            else w_idx_n = w_above_vld ? w_above : w_low;
        end else begin
            w_cnt_n = r_cnt + 1'b1;
        end
    end

    always_comb begin
        w_bcd      = '0;
        w_bcd[3:0] = 4'(int'(w_idx_n) % 10);
        w_bcd[7:4] = 4'(int'(w_idx_n) / 10);
    end

    // The display encodes the post-edge flags and scan state, so every input change lands one cycle later.
    assign w_seg_n = !bus.mem_calib_done ? C_UNCAL :
                     w_mem_n             ? C_MEM   :
                     w_vga_n             ? C_VGA   :
                     (w_state_n == SHOW) ? w_bcd   : C_DEF;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_idx   <= '0;
            r_cnt   <= '0;
            r_mem   <= 1'b0;
            r_vga   <= 1'b0;
            r_seg   <= C_DEF;
        end else begin
            r_state <= w_state_n;
            r_idx   <= w_idx_n;
            r_cnt   <= w_cnt_n;
            r_mem   <= w_mem_n;
            r_vga   <= w_vga_n;
            r_seg   <= w_seg_n;
        end
    end

    assign bus.seg_digits   = r_seg;
    assign bus.sticky_flags = {r_vga, r_mem};
endmodule

// File: doc/seg_status_scan.md
Name: seg_status_scan

Overview:
- Parametrised successor to the combinational 7-segment status encoder.
- Registers the display word and latches memory and VGA faults as sticky until cleared.
- Cycles through all simultaneously active user inputs with a minimum dwell time, and shows the input index in BCD.
- Sits between the memory controller / VGA buffer / input debouncer and the 7-segment driver.

Parameters:
- NUM_INPUTS, 14, number of buffered user inputs; legal range 1..100.
- NUM_DIGITS, 3, number of hex digits driven; must be >= 2; output width is 4*NUM_DIGITS.
- HOLD_CYCLES, 25000000, minimum dwell cycles per displayed input index; must be >= 1.
- CODE_UNCALIB, 'hC00, display word while memory is uncalibrated; zero-extended/truncated to 4*NUM_DIGITS.
- CODE_MEM_ERR, 'hE01, display word for sticky memory error.
- CODE_VGA_EMPTY, 'hE02, display word for sticky VGA underflow.
- CODE_DEFAULT, 'hFFF, display word when idle.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- mem_calib_done  in  1  LPDDR calibration complete (level).
- mem_error  in  1  LPDDR bit error (level or pulse).
- vga_buf_empty  in  1  VGA buffer empty (level or pulse).
- clear_sticky  in  1  one-cycle pulse; clears both sticky flags.
- buf_inputs  in  NUM_INPUTS  buffered user inputs, active high.
- seg_digits  out  4*NUM_DIGITS  registered display word.
- sticky_flags  out  2  registered {vga_sticky, mem_sticky}.

Behaviour:
- Reset values: seg_digits = CODE_DEFAULT; sticky_flags = 0; FSM = IDLE; cur_idx = 0; hold_cnt = 0.
- All state updates on posedge clk. Reset has priority over every other input.
- Sticky flags:
  - Set only while mem_calib_done = 1: mem_sticky by mem_error, vga_sticky by vga_buf_empty.
  - clear_sticky clears both flags. If set and clear occur in the same cycle, set wins.
  - mem_calib_done = 0 clears both flags. Faults during or before calibration are ignored.
- Display priority, evaluated on current-cycle inputs and flags:
  1. !mem_calib_done -> CODE_UNCALIB
  2. mem_sticky, or mem_error this cycle -> CODE_MEM_ERR
  3. vga_sticky, or vga_buf_empty this cycle -> CODE_VGA_EMPTY
  4. FSM = SHOW -> BCD(cur_idx)
  5. otherwise -> CODE_DEFAULT
- Latency: seg_digits reflects any input change exactly 1 cycle later. A fault shows on the cycle after it is asserted and stays until cleared.
- BCD(cur_idx): digit0 = cur_idx mod 10, digit1 = cur_idx / 10, all higher digits 0. Example: index 13 -> 'h013.
- Input FSM, states IDLE and SHOW:
  - IDLE: if priorities 1–3 are inactive and buf_inputs != 0, load cur_idx = lowest set bit, set hold_cnt = 0, go to SHOW.
  - SHOW: hold_cnt increments every cycle. When hold_cnt = HOLD_CYCLES-1:
    - set hold_cnt = 0;
    - if buf_inputs == 0, go to IDLE;
    - otherwise load cur_idx = lowest set bit strictly above cur_idx, wrapping to the lowest set bit overall. If cur_idx is the only active bit, it stays.
  - The displayed index is held for its full dwell even if its input releases early. This gives a release hold of up to HOLD_CYCLES.
  - Any of priorities 1–3 active forces FSM = IDLE and hold_cnt = 0 on the next edge. When they clear, the FSM re-enters from IDLE; scan position is not preserved.
- Width rules:
  - hold_cnt is sized clog2(HOLD_CYCLES), minimum 1 bit, and never exceeds HOLD_CYCLES-1.
  - cur_idx is sized clog2(NUM_INPUTS), minimum 1 bit.
  - Code parameters are resized to 4*NUM_DIGITS bits.
- With HOLD_CYCLES = 1 every cycle is an expiry cycle, so the display advances each cycle.

Test Plan:
- Reset and calibration (HOLD_CYCLES=4): rst high 2 cycles -> seg_digits='hFFF, sticky_flags=0. Then calib=0 -> 'hC00 one cycle later. Then mem_error pulse while calib=0 -> sticky_flags stays 0.
- Sticky fault: calib=1, mem_error 1-cycle pulse -> 'hE01 next cycle, held 20 cycles, sticky_flags=2'b01. Pulse clear_sticky -> 'hFFF next cycle. Clear and vga_buf_empty in the same cycle -> vga_sticky=1, display 'hE02.
- Scan: calib=1, buf_inputs bits 2, 9, 13 held -> display sequence 'h002, 'h009, 'h013, 'h002, each for exactly 4 cycles.
- Release hold: bit 5 asserted 1 cycle -> 'h005 for exactly 4 cycles, then 'hFFF.
- Override mid-scan: bits 0 and 11 active, vga_buf_empty pulse during the 'h011 dwell -> 'hE02 next cycle. After clear_sticky -> scan restarts at 'h000 with a full 4-cycle dwell.
- Parametrisation: NUM_INPUTS=40, NUM_DIGITS=4, bit 37 -> seg_digits='h0037. HOLD_CYCLES=1 with bits 1 and 3 -> display alternates 'h0001 and 'h0003 every cycle.
